// File: rtl/ustawienie_pola_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ustawienie_pola_seq_if
//  Description : Operand/result handshake bundle for the bit/field setter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ustawienie_pola_seq_if #(
    parameter int BITS = 32
);
    localparam int LEN_W = $clog2(BITS) + 1;

    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_op;
    logic [BITS-1:0]  i_arg_A;
    logic [BITS-1:0]  i_arg_B;
    logic [LEN_W-1:0] i_len;
    logic [BITS-1:0]  o_result;
    logic             o_error;
    logic             o_valid;
    logic             i_out_ready;

    modport master (
        output i_valid, i_op, i_arg_A, i_arg_B, i_len, i_out_ready,
        input  o_ready, o_result, o_error, o_valid
    );

    modport slave (
        input  i_valid, i_op, i_arg_A, i_arg_B, i_len, i_out_ready,
        output o_ready, o_result, o_error, o_valid
    );
endinterface
`default_nettype wire

// File: rtl/ustawienie_pola_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ustawienie_pola_seq
//  Description : SET/CLR/TGL one bit or SET a field (one bit per clock) at an
//                MSB-first index, with valid/ready in and held result out.
//  Revision    : 1.0 - initial release
// ============================================================================
module ustawienie_pola_seq #(
    parameter int BITS = 32
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    ustawienie_pola_seq_if.slave   bus
);
    localparam int LEN_W = $clog2(BITS) + 1;
    localparam int IDX_W = $clog2(BITS);

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_CLR = 2'd1;
    localparam logic [1:0] OP_TGL = 2'd2;
    localparam logic [1:0] OP_FLD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  work_q, work_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic [1:0]       op_q, op_d;
    logic [BITS-1:0]  result_q, result_d;
    logic             error_q, error_d;

    logic             w_b_neg;
    logic             w_b_big;
    logic [BITS:0]    w_fld_end;
    logic             w_fld_bad;
    logic             w_err;
    logic [IDX_W-1:0] w_pos_init;
    logic [BITS-1:0]  w_work_upd;

    // Field end is formed one bit wider than the operand so B+len cannot wrap.
    assign w_b_neg    = bus.i_arg_B[BITS-1];
    assign w_b_big    = bus.i_arg_B >= BITS'(BITS);
    assign w_fld_end  = {1'b0, bus.i_arg_B} + {{(BITS+1-LEN_W){1'b0}}, bus.i_len};
    assign w_fld_bad  = (bus.i_len == '0) || (w_fld_end > (BITS+1)'(BITS));
    assign w_err      = w_b_neg || w_b_big || ((bus.i_op == OP_FLD) && w_fld_bad);
    assign w_pos_init = IDX_W'(BITS - 1) - bus.i_arg_B[IDX_W-1:0];

    always_comb begin
        w_work_upd = work_q;
        case (op_q)
            OP_SET:  w_work_upd[pos_q] = 1'b1;
            OP_CLR:  w_work_upd[pos_q] = 1'b0;
            OP_TGL:  w_work_upd[pos_q] = ~work_q[pos_q];
            default: w_work_upd[pos_q] = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        op_d     = op_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    op_d   = bus.i_op;
                    work_d = bus.i_arg_A;
                    if (w_err) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        error_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = (bus.i_op == OP_FLD) ? bus.i_len : LEN_W'(1);
                        pos_d   = w_pos_init;
                    end
                end
            end

            S_BUSY: begin
                work_d = w_work_upd;
                cnt_d  = cnt_q - LEN_W'(1);
                pos_d  = pos_q - IDX_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = w_work_upd;
                    error_d  = 1'b0;
                end
            end

            S_DONE: begin
                // Result is cleared on hand-off so o_result reads 0 while idle.
                if (bus.i_out_ready) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    error_d  = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                result_d = '0;
                error_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            op_q     <= OP_SET;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            op_q     <= op_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign bus.o_ready  = (state_q == S_IDLE);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_result = result_q;
    assign bus.o_error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ustawienie_pola_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ustawienie_pola_seq
//  Description : Scoreboard bench for ustawienie_pola_seq (directed + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ustawienie_pola_seq;
    localparam int BITS  = 32;
    localparam int LEN_W = 6;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          lat;
        int          n;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ustawienie_pola_seq_if #(.BITS(BITS)) bus ();

    ustawienie_pola_seq #(.BITS(BITS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   hold_rdy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream readiness: random unless a test pins it low.
    always @(posedge clk) begin
        #3;
        bus.i_out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: index k names bit 31-k; a field of len bits runs downward from there.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [5:0] len);
        exp_t        x;
        longint      bs;
        int          p;
        logic [63:0] m;
        bs    = longint'($signed(b));
        x.n   = 0;
        if (bs < 0 || bs >= 32 || (op == 2'd3 && (len == 0 || bs + longint'(len) > 32))) begin
            x.r = 32'h0; x.e = 1'b1; x.lat = 1;
        end else begin
            p   = 31 - int'(bs);
            x.e = 1'b0;
            case (op)
                2'd0: begin x.r = a | (32'h1 << p);  x.lat = 2; end
                2'd1: begin x.r = a & ~(32'h1 << p); x.lat = 2; end
                2'd2: begin x.r = a ^ (32'h1 << p);  x.lat = 2; end
                default: begin
                    m     = ((64'h1 << len) - 64'h1) << (32 - int'(bs) - int'(len));
                    x.r   = a | m[31:0];
                    x.lat = 1 + int'(len);
                end
            endcase
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] len);
        exp_t x;
        int   w = 0;
        while (bus.o_ready !== 1'b1 && w < 500) begin
            step();
            w++;
        end
        if (w >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: o_ready=%b required 1", bus.o_ready);
            return;
        end
        bus.i_op    = op;
        bus.i_arg_A = a;
        bus.i_arg_B = b;
        bus.i_len   = len;
        bus.i_valid = 1'b1;
        x = model(op, a, b, len);
        @(posedge clk);
        #1;
        x.n = cyc;
        sb.push_back(x);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op    = 2'($urandom);
        bus.i_arg_A = $urandom;
        bus.i_arg_B = $urandom;
        bus.i_len   = LEN_W'($urandom);
    endtask

    task automatic wait_valid();
        int w = 0;
        while (bus.o_valid !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: o_valid=%b required 1", bus.o_valid);
        end
    endtask

    // Monitor: pops on every hand-off edge and checks value, error and latency.
    bit   prev_v  = 1'b0;
    int   first_m = 0;
    exp_t got;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.o_valid === 1'b1 && !prev_v) first_m = cyc;
            prev_v = (bus.o_valid === 1'b1);
            if (bus.o_valid !== 1'b1) chk("idle_result_zero", bus.o_result, 32'h0);
            if (bus.o_valid === 1'b1 && bus.i_out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: result %h with empty scoreboard", bus.o_result);
                end else begin
                    got = sb.pop_front();
                    chk("result",  bus.o_result, got.r);
                    chk("error",   32'(bus.o_error), 32'(got.e));
                    chk("latency", 32'(first_m + 1 - got.n), 32'(got.lat));
                end
            end
        end
    end

    exp_t bp;
    int   w;
    logic [31:0] ra, rb;
    logic [5:0]  rl;
    int   sel;

    initial begin
        bus.i_valid = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_arg_A = '0;
        bus.i_arg_B = '0;
        bus.i_len   = '0;
        repeat (2) @(posedge clk);
        #2;
        bus.i_valid = 1'b1;
        step();
        chk("rst_valid",  32'(bus.o_valid), 32'h0);
        chk("rst_result", bus.o_result,     32'h0);
        chk("rst_error",  32'(bus.o_error), 32'h0);
        bus.i_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(bus.o_ready), 32'h1);

        hold_rdy = 1'b0;
        issue(2'd0, 32'h0000_0000, 32'd0,  6'd0);
        issue(2'd1, 32'hFFFF_FFFF, 32'd31, 6'd0);
        issue(2'd2, 32'h0000_00F0, 32'd27, 6'd0);
        issue(2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 6'd0);
        issue(2'd1, 32'h1234_5678, 32'd32, 6'd0);
        issue(2'd3, 32'h0,         32'd28, 6'd5);
        issue(2'd3, 32'h0,         32'd3,  6'd0);
        issue(2'd3, 32'h0,         32'd4,  6'd8);
        issue(2'd3, 32'h0,         32'd0,  6'd32);
        issue(2'd3, 32'h0,         32'd28, 6'd4);

        // Backpressure: result must hold and a stray i_valid must be ignored.
        w = 0;
        while (sb.size() != 0 && w < 500) begin step(); w++; end
        hold_rdy = 1'b1;
        step();
        issue(2'd2, 32'hA5A5_0F0F, 32'd5, 6'd0);
        bp = model(2'd2, 32'hA5A5_0F0F, 32'd5, 6'd0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(bus.o_valid), 32'h1);
            chk("bp_result", bus.o_result,     bp.r);
            chk("bp_error",  32'(bus.o_error), 32'(bp.e));
            chk("bp_ready",  32'(bus.o_ready), 32'h0);
            bus.i_valid = (i == 1);
            bus.i_op    = 2'd3;
            bus.i_arg_B = 32'd0;
            bus.i_len   = 6'd1;
            step();
        end
        bus.i_valid = 1'b0;
        hold_rdy = 1'b0;
        issue(2'd0, 32'h0, 32'd16, 6'd0);

        // Asynchronous reset mid-field and while holding a result.
        w = 0;
        while (sb.size() != 0 && w < 500) begin step(); w++; end
        hold_rdy = 1'b1;
        step();
        issue(2'd3, 32'h0, 32'd8, 6'd16);
        step(); step();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_busy_valid",  32'(bus.o_valid), 32'h0);
        chk("arst_busy_result", bus.o_result,     32'h0);
        step();
        rst_n = 1'b1;
        step();
        issue(2'd1, 32'hFFFF_FFFF, 32'd0, 6'd0);
        wait_valid();
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_done_valid",  32'(bus.o_valid), 32'h0);
        chk("arst_done_result", bus.o_result,     32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ready", 32'(bus.o_ready), 32'h1);
        hold_rdy = 1'b0;
        issue(2'd0, 32'h0, 32'd31, 6'd0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            if (sel == 0)      rb = $urandom;
            else if (sel == 1) rb = 32'd32 + 32'($urandom_range(0, 5));
            else               rb = 32'($urandom_range(0, 31));
            rl = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            issue(2'($urandom_range(0, 3)), ra, rb, rl);
        end

        w = 0;
        while (sb.size() != 0 && w < 2000) begin step(); w++; end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
